// File: rtl/fifo_to_sram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_to_sram_loader
//  Description : Moves a block of 32-bit words from the HPS-to-FPGA Avalon FIFO
//                into on-chip SRAM starting at word address 0. The block polls
//                the FIFO fill level and bursts out only words that are already
//                present. It then pulses done so the solver core can start.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_to_sram_loader #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int POLL_GAP = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    output logic [2:0]        fifo_csr_address,
    output logic              fifo_csr_read,
    input  logic [31:0]       fifo_csr_readdata,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_readdata,
    input  logic              fifo_waitrequest,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    output logic [3:0]        sram_byteenable,
    output logic              sram_clken,
    output logic              busy,
    output logic              done
);

    // Word counters need one extra bit so a full 2^ADDR_W load is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(POLL_GAP - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_POLL     = 3'd1;
    localparam logic [2:0] S_CSR_WAIT = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_READ     = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]        r_state;
    logic              r_start_q;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_burst;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_csr_rd;
    logic              r_fifo_rd;
    logic              r_sram_wr;
    logic              r_busy;
    logic              r_done;

    logic [31:0]       w_remaining_ext;
    logic [CNT_W-1:0]  w_avail;
    logic              w_start_rise;

    assign w_start_rise    = start & ~r_start_q;
    assign w_remaining_ext = 32'(r_remaining);

    // Words we may pop this burst: the fill level, clamped so that surplus
    // words beyond the requested count stay in the FIFO.
    assign w_avail = (fifo_csr_readdata >= w_remaining_ext) ? r_remaining
                                                            : fifo_csr_readdata[CNT_W-1:0];

    assign fifo_csr_address = 3'd0;
    assign fifo_csr_read    = r_csr_rd;
    assign fifo_read        = r_fifo_rd;
    assign sram_address     = r_addr;
    assign sram_chipselect  = r_sram_wr;
    assign sram_write       = r_sram_wr;
    assign sram_writedata   = r_wdata;
    assign sram_byteenable  = 4'hF;
    assign sram_clken       = 1'b1;
    assign busy             = r_busy;
    assign done             = r_done;

    // Load sequencer: strobes are registered and set on entry to the state
    // that owns them, so each strobe is high exactly while that state is live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_gap_cnt   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_csr_rd    <= 1'b0;
            r_fifo_rd   <= 1'b0;
            r_sram_wr   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_q <= start;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Edges seen outside IDLE are dropped, never queued.
                    if (w_start_rise) begin
                        r_remaining <= num_words;
                        r_addr      <= '0;
                        r_busy      <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state  <= S_POLL;
                            r_csr_rd <= 1'b1;
                        end
                    end
                end
                S_POLL: begin
                    r_csr_rd <= 1'b0;
                    r_state  <= S_CSR_WAIT;
                end
                S_CSR_WAIT: begin
                    if (w_avail == '0) begin
                        if (POLL_GAP == 0) begin
                            r_state  <= S_POLL;
                            r_csr_rd <= 1'b1;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end else begin
                        r_burst   <= w_avail;
                        r_fifo_rd <= 1'b1;
                        r_state   <= S_READ;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state  <= S_POLL;
                        r_csr_rd <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    // Read strobe stays up through any stall; data is taken
                    // only in the cycle the FIFO releases waitrequest.
                    if (!fifo_waitrequest) begin
                        r_wdata   <= fifo_readdata;
                        r_fifo_rd <= 1'b0;
                        r_sram_wr <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_sram_wr   <= 1'b0;
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_burst     <= r_burst - 1'b1;
                    if (r_remaining == c_cnt_one) begin
                        r_state <= S_DONE;
                    end else if (r_burst == c_cnt_one) begin
                        r_state  <= S_POLL;
                        r_csr_rd <= 1'b1;
                    end else begin
                        r_state   <= S_READ;
                        r_fifo_rd <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_csr_rd  <= 1'b0;
                    r_fifo_rd <= 1'b0;
                    r_sram_wr <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_to_sram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_to_sram_loader
//  Description : Self-checking bench for fifo_to_sram_loader. A behavioural
//                FIFO/CSR model answers the DUT; expected SRAM writes are
//                queued as words are loaded into the model and compared as the
//                DUT writes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_to_sram_loader;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int POLL_GAP = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [2:0]        fifo_csr_address;
    logic              fifo_csr_read;
    logic [31:0]       fifo_csr_readdata = '0;
    logic              fifo_read;
    logic [DATA_W-1:0] fifo_readdata = '0;
    logic              fifo_waitrequest = 1'b0;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_chipselect;
    logic              sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic [3:0]        sram_byteenable;
    logic              sram_clken;
    logic              busy;
    logic              done;

    fifo_to_sram_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .POLL_GAP (POLL_GAP)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .num_words         (num_words),
        .fifo_csr_address  (fifo_csr_address),
        .fifo_csr_read     (fifo_csr_read),
        .fifo_csr_readdata (fifo_csr_readdata),
        .fifo_read         (fifo_read),
        .fifo_readdata     (fifo_readdata),
        .fifo_waitrequest  (fifo_waitrequest),
        .sram_address      (sram_address),
        .sram_chipselect   (sram_chipselect),
        .sram_write        (sram_write),
        .sram_writedata    (sram_writedata),
        .sram_byteenable   (sram_byteenable),
        .sram_clken        (sram_clken),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fifo_q[$];
    int          fill_resp[$];
    int          poll_cyc[$];

    int total = 0;
    int bad   = 0;

    int          poll_cnt = 0, pop_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int          overlap_cnt = 0, underflow = 0, extra_wr = 0;
    int          first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, st_cyc = 0;
    int          stall_idx = -1, stall_left = 0;
    int          csr_resp = 0;
    bit          csr_pend = 1'b0, prev_wait = 1'b0;
    logic [ADDR_W-1:0] exp_done_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // FIFO/CSR responder and SRAM-side scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            csr_pend          = 1'b0;
            prev_wait         = 1'b0;
            fifo_csr_readdata = '0;
            fifo_waitrequest  = 1'b0;
            fifo_readdata     = '0;
        end else begin
            if (fifo_read && fifo_csr_read) overlap_cnt++;

            // CSR data is only valid in the cycle after the read strobe.
            fifo_csr_readdata = csr_pend ? 32'(csr_resp) : 32'd0;
            csr_pend = 1'b0;
            if (fifo_csr_read) begin
                poll_cnt++;
                poll_cyc.push_back(cyc);
                csr_pend = 1'b1;
                if (fill_resp.size() > 0) csr_resp = fill_resp.pop_front();
                else                      csr_resp = fifo_q.size();
            end

            if (prev_wait) check_eq("rd_hold", 32'(fifo_read), 32'd1);

            if (fifo_read) begin
                if (stall_left > 0 && pop_cnt == stall_idx) begin
                    fifo_waitrequest = 1'b1;
                    fifo_readdata    = 32'hBAD0_0000 | 32'(cyc);
                    stall_left--;
                end else begin
                    fifo_waitrequest = 1'b0;
                    if (fifo_q.size() > 0) begin
                        fifo_readdata = fifo_q.pop_front();
                    end else begin
                        underflow++;
                        fifo_readdata = 32'hDEAD_0000;
                    end
                    pop_cnt++;
                end
            end else begin
                fifo_waitrequest = 1'b0;
                fifo_readdata    = 32'hBAD0_0000 ^ 32'(cyc);
            end
            prev_wait = fifo_read && fifo_waitrequest;

            if (sram_write) begin
                check_eq("wr_cs", 32'(sram_chipselect), 32'd1);
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    extra_wr++;
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(sram_address), 32'(e.a));
                    check_eq("wr_data", sram_writedata, e.d);
                end
            end

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("addr_at_done", 32'(sram_address), 32'(exp_done_addr));
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_strobes"},
                 32'({fifo_csr_read, fifo_read, sram_write, sram_chipselect, busy, done}), 32'd0);
        check_eq({tag, "_addr"}, 32'(sram_address), 32'd0);
        check_eq({tag, "_wdata"}, sram_writedata, 32'd0);
        check_eq({tag, "_csraddr"}, 32'(fifo_csr_address), 32'd0);
        check_eq({tag, "_byteen"}, 32'(sram_byteenable), 32'hF);
        check_eq({tag, "_clken"}, 32'(sram_clken), 32'd1);
    endtask

    // One load: stock the FIFO model, queue expected writes, pulse start and
    // wait (bounded) for done, then audit the whole transaction.
    task automatic run_load(input int n, input int extra, input int exp_polls,
                            input bit toggle, input bit hold);
        int base_done, base_poll, base_pop, left_exp, t;
        logic [31:0] w;
        for (int i = 0; i < n + extra; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
        end
        for (int i = 0; i < n; i++) exp_q.push_back('{a: ADDR_W'(i), d: fifo_q[i]});
        left_exp      = fifo_q.size() - n;
        base_done     = done_cnt;
        base_poll     = poll_cnt;
        base_pop      = pop_cnt;
        wr_cnt        = 0;
        extra_wr      = 0;
        exp_done_addr = ADDR_W'(n);
        poll_cyc.delete();

        @(negedge clk);
        num_words = (ADDR_W+1)'(n);
        start     = 1'b1;
        st_cyc    = cyc;
        @(negedge clk);
        check_eq("busy_on", 32'(busy), 32'd1);
        if (toggle) begin
            repeat (2) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == base_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!hold) start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b0;

        check_eq("done_pulses", 32'(done_cnt - base_done), 32'd1);
        check_eq("polls", 32'(poll_cnt - base_poll), 32'(exp_polls));
        check_eq("pops", 32'(pop_cnt - base_pop), 32'(n));
        check_eq("writes", 32'(wr_cnt), 32'(n));
        check_eq("exp_left", 32'(exp_q.size()), 32'd0);
        check_eq("fifo_left", 32'(fifo_q.size()), 32'(left_exp));
        check_eq("extra_wr", 32'(extra_wr), 32'd0);
        check_eq("underflow", 32'(underflow), 32'd0);
        check_eq("overlap", 32'(overlap_cnt), 32'd0);
        check_eq("busy_off", 32'(busy), 32'd0);
        if (n == 0) check_eq("done_lat0", 32'(done_cyc - st_cyc), 32'd2);
        else        check_eq("first_wr_lat_ge4", 32'((first_wr_cyc - st_cyc) >= 4), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n   = 1'b0;
        start     = 1'b0;
        num_words = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single burst, back-to-back words two cycles apart.
        run_load(4, 0, 1, 1'b0, 1'b0);
        check_eq("t1_wr_span", 32'(last_wr_cyc - first_wr_cyc), 32'd6);

        // Empty FIFO for three polls; polls must be evenly spaced.
        fill_resp = '{0, 0, 0};
        run_load(3, 0, 4, 1'b0, 1'b0);
        if (poll_cyc.size() >= 4)
            for (int i = 1; i < 4; i++)
                check_eq("poll_spacing", 32'(poll_cyc[i] - poll_cyc[i-1]), 32'(POLL_GAP + 2));

        // Two bursts (2 then 3); a start re-edge while busy must be ignored.
        fill_resp = '{2, 3};
        run_load(5, 0, 2, 1'b1, 1'b0);

        // Five-cycle stall on the second word of a burst.
        stall_idx  = pop_cnt + 1;
        stall_left = 5;
        run_load(3, 0, 1, 1'b0, 1'b0);
        check_eq("stall_used", 32'(stall_left), 32'd0);

        // Fill level above request is clamped; start held high gives one load.
        run_load(2, 2, 1, 1'b0, 1'b1);
        // Leftover words are drained by the next load, again from address 0.
        run_load(2, 0, 1, 1'b0, 1'b0);

        // Zero-length load: no bus traffic, done two cycles after the edge.
        run_load(0, 0, 0, 1'b0, 1'b0);

        // Reset while the second word is in flight.
        for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
        wr_cnt = 0;
        t = done_cnt;
        @(negedge clk);
        num_words = (ADDR_W+1)'(4);
        start     = 1'b1;
        for (int k = 0; k < 200 && wr_cnt == 0; k++) @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        start = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fill_resp.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("no_done_on_abort", 32'(done_cnt - t), 32'd0);
        run_load(3, 0, 1, 1'b0, 1'b0);

        // Full-depth load: address wraps back to 0 at completion.
        run_load(1 << ADDR_W, 0, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
